// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen: quadrature A/B waveform generator driven by signed step commands
// Ports: iCLK/iRESET clock and async active-high reset; iCMD_VALID/oCMD_READY/iCMD_STEPS/iCMD_PERIOD
// command handshake; iABORT stops a run; iPOS_CLEAR zeroes oPOSITION; oENC_A/oENC_B quadrature
// outputs; oBUSY running; oDONE completion pulse; oPOSITION signed running edge count.
module quad_encoder_gen #(
  parameter int pSTEP_BITS = 16,
  parameter int pDIV_BITS  = 16
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  input  logic                  iCMD_VALID,
  output logic                  oCMD_READY,
  input  logic [pSTEP_BITS-1:0] iCMD_STEPS,
  input  logic [pDIV_BITS-1:0]  iCMD_PERIOD,
  input  logic                  iABORT,
  input  logic                  iPOS_CLEAR,
  output logic                  oENC_A,
  output logic                  oENC_B,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic [pSTEP_BITS-1:0] oPOSITION
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [pSTEP_BITS-1:0] rem_q, rem_d, pos_q, pos_d;
  logic [pDIV_BITS-1:0]  per_q, per_d, div_q, div_d, per_in;
  logic [1:0]            ab_q, ab_d;
  logic                  done_q, done_d, step;
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    per_d   = per_q;
    div_d   = div_q;
    ab_d    = ab_q;
    done_d  = 1'b0;
    per_in  = (iCMD_PERIOD == '0) ? pDIV_BITS'(1) : iCMD_PERIOD;
    step    = (state_q == RUN) && !iABORT && (div_q == '0);
    if (state_q == IDLE && iCMD_VALID) begin
      if (iCMD_STEPS == '0) done_d = 1'b1;
      else begin
        state_d = RUN;
        dir_d   = iCMD_STEPS[pSTEP_BITS-1];
        rem_d   = dir_d ? -iCMD_STEPS : iCMD_STEPS;
        per_d   = per_in;
        div_d   = per_in - pDIV_BITS'(1);
      end
    end else if (state_q == RUN) begin
      if (iABORT) state_d = IDLE;
      else if (div_q != '0) div_d = div_q - pDIV_BITS'(1);
      else begin
        // {A,B} forward 00->01->11->10 is {B,~A}; reverse is {~B,A}
        ab_d  = dir_q ? {~ab_q[0], ab_q[1]} : {ab_q[0], ~ab_q[1]};
        rem_d = rem_q - pSTEP_BITS'(1);
        div_d = per_q - pDIV_BITS'(1);
        if (rem_q == pSTEP_BITS'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
    pos_d = iPOS_CLEAR ? '0 : !step ? pos_q : dir_q ? pos_q - pSTEP_BITS'(1) : pos_q + pSTEP_BITS'(1);
  end
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      per_q   <= '0;
      div_q   <= '0;
      ab_q    <= 2'b00;
      pos_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      per_q   <= per_d;
      div_q   <= div_d;
      ab_q    <= ab_d;
      pos_q   <= pos_d;
      done_q  <= done_d;
    end
  end
  assign oENC_A     = ab_q[1];
  assign oENC_B     = ab_q[0];
  assign oBUSY      = (state_q == RUN);
  assign oCMD_READY = (state_q == IDLE);
  assign oDONE      = done_q;
  assign oPOSITION  = pos_q;
endmodule
